// File: rtl/alu_bist.sv
// Built-in self-test engine for the 16-bit datapath ALU: sweeps every supported
// operation over a square operand window, counts mismatches, latches the first failure.
module alu_bist #(
  parameter int WIDTH    = 16,
  parameter int SWEEP_LO = -256,
  parameter int SWEEP_N  = 511,
  parameter int ERR_W    = 24
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrCount,
  output logic [2:0]       FailCtl,
  output logic             FailFlip,
  output logic [WIDTH-1:0] FailA,
  output logic [WIDTH-1:0] FailB,
  output logic [WIDTH-1:0] FailOut,
  output logic [2:0]       ALUct1,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Flip,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic             Zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [WIDTH-1:0] LO_V    = WIDTH'(SWEEP_LO);
  localparam logic [WIDTH-1:0] HI_V    = WIDTH'(SWEEP_LO + SWEEP_N - 1);
  localparam logic [2:0]       LAST_PH = 3'd6;

  // Phase index -> {ALUct1, Flip}
  function automatic logic [3:0] phase_op(input logic [2:0] ph);
    case (ph)
      3'd0:    phase_op = {3'd0, 1'b0};
      3'd1:    phase_op = {3'd1, 1'b0};
      3'd2:    phase_op = {3'd2, 1'b0};
      3'd3:    phase_op = {3'd6, 1'b0};
      3'd4:    phase_op = {3'd7, 1'b0};
      3'd5:    phase_op = {3'd6, 1'b1};
      default: phase_op = {3'd7, 1'b1};
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         ph_q, ph_d;
  logic [2:0]         ctl_q, ctl_d;
  logic               flip_q, flip_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               chk_q, chk_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic [2:0]         fctl_q, fctl_d;
  logic               fflip_q, fflip_d;
  logic [WIDTH-1:0]   fa_q, fa_d, fb_q, fb_d, fout_q, fout_d;

  logic [WIDTH-1:0]   gold;
  logic               lt;
  logic               mism;
  logic               vec_last;

  always_comb begin
    lt = flip_q ? ($signed(b_q) < $signed(a_q)) : ($signed(a_q) < $signed(b_q));
    case (ctl_q)
      3'd0:    gold = a_q & b_q;
      3'd1:    gold = a_q | b_q;
      3'd2:    gold = a_q + b_q;
      3'd6:    gold = flip_q ? (b_q - a_q) : (a_q - b_q);
      3'd7:    gold = {{(WIDTH-1){1'b0}}, lt};
      default: gold = '0;
    endcase
    mism     = chk_q && ((ALUOut != gold) || (Zero != (gold == '0)));
    vec_last = (ph_q == LAST_PH) && (a_q == HI_V) && (b_q == HI_V);
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    ctl_d   = ctl_q;
    flip_d  = flip_q;
    a_d     = a_q;
    b_d     = b_q;
    chk_d   = chk_q;
    err_d   = err_q;
    pass_d  = pass_q;
    fctl_d  = fctl_q;
    fflip_d = fflip_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fout_d  = fout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d         = S_RUN;
          ph_d            = '0;
          {ctl_d, flip_d} = phase_op(3'd0);
          a_d             = LO_V;
          b_d             = LO_V;
          chk_d           = 1'b1;
          err_d           = '0;
          pass_d          = 1'b0;
          fctl_d          = '0;
          fflip_d         = 1'b0;
          fa_d            = '0;
          fb_d            = '0;
          fout_d          = '0;
        end
      end
      S_RUN: begin
        if (chk_q) begin
          if (mism) begin
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            if (err_q == '0) begin
              fctl_d  = ctl_q;
              fflip_d = flip_q;
              fa_d    = a_q;
              fb_d    = b_q;
              fout_d  = ALUOut;
            end
          end
          // Last vector stays on the ports; one drain cycle follows its check.
          if (vec_last) begin
            chk_d = 1'b0;
          end else if (a_q != HI_V) begin
            a_d = a_q + WIDTH'(1);
          end else begin
            a_d = LO_V;
            if (b_q != HI_V) begin
              b_d = b_q + WIDTH'(1);
            end else begin
              b_d             = LO_V;
              ph_d            = ph_q + 3'd1;
              {ctl_d, flip_d} = phase_op(ph_q + 3'd1);
            end
          end
        end else begin
          state_d = S_DONE;
          pass_d  = (err_q == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      ctl_q   <= '0;
      flip_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      chk_q   <= 1'b0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fctl_q  <= '0;
      fflip_q <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fout_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      ctl_q   <= ctl_d;
      flip_q  <= flip_d;
      a_q     <= a_d;
      b_q     <= b_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fctl_q  <= fctl_d;
      fflip_q <= fflip_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fout_q  <= fout_d;
    end
  end

  assign Busy     = (state_q == S_RUN);
  assign Done     = (state_q == S_DONE);
  assign Pass     = pass_q;
  assign ErrCount = err_q;
  assign FailCtl  = fctl_q;
  assign FailFlip = fflip_q;
  assign FailA    = fa_q;
  assign FailB    = fb_q;
  assign FailOut  = fout_q;
  assign ALUct1   = ctl_q;
  assign Flip     = flip_q;
  assign A        = a_q;
  assign B        = b_q;

endmodule
